// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch sequencer state encoding and default widths.
package cpu_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int ADDR_W_DEF      = 8;
  localparam int OPERAND_BIT_DEF = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OP    = 3'd1,
    S_ARG   = 3'd2,
    S_ISSUE = 3'd3,
    S_JUMP  = 3'd4,
    S_HALT  = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads opcode/operand bytes at the program counter,
// steps or reloads the counter, and hands complete instructions to the decoder.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int OPERAND_BIT = OPERAND_BIT_DEF
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_en,
  output logic              pc_in,
  output logic [ADDR_W-1:0] pc_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_opcode,
  output logic [DATA_W-1:0] ir_operand,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              jmp_req,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              halt
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] ir_opcode_q, ir_opcode_d;
  logic [DATA_W-1:0] ir_operand_q, ir_operand_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic [ADDR_W-1:0] pc_data_q, pc_data_d;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ir_opcode_q  <= '0;
      ir_operand_q <= '0;
      ir_pc_q      <= '0;
      pc_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      ir_opcode_q  <= ir_opcode_d;
      ir_operand_q <= ir_operand_d;
      ir_pc_q      <= ir_pc_d;
      pc_data_q    <= pc_data_d;
    end
  end

  // pc_en fires in the same cycle as the ack so the counter has already
  // advanced when the next byte is requested.
  always_comb begin
    state_d      = state_q;
    ir_opcode_d  = ir_opcode_q;
    ir_operand_d = ir_operand_q;
    ir_pc_d      = ir_pc_q;
    pc_data_d    = pc_data_q;
    pc_en        = 1'b0;
    pc_in        = 1'b0;
    mem_req      = 1'b0;
    ir_valid     = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_OP;
      S_OP: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          pc_en        = 1'b1;
          ir_pc_d      = pc_addr;
          ir_opcode_d  = mem_rdata;
          ir_operand_d = '0;
          state_d      = mem_rdata[OPERAND_BIT] ? S_ARG : S_ISSUE;
        end
      end
      S_ARG: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          pc_en        = 1'b1;
          ir_operand_d = mem_rdata;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ir_valid = 1'b1;
        if (ir_ready) begin
          if (halt) begin
            state_d = S_HALT;
          end else if (jmp_req) begin
            pc_data_d = jmp_target;
            state_d   = S_JUMP;
          end else begin
            state_d = S_OP;
          end
        end
      end
      S_JUMP: begin
        pc_en   = 1'b1;
        pc_in   = 1'b1;
        state_d = S_OP;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr   = mem_req ? pc_addr : '0;
  assign pc_data    = pc_data_q;
  assign ir_opcode  = ir_opcode_q;
  assign ir_operand = ir_operand_q;
  assign ir_pc      = ir_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a program-counter model and a
// byte memory model that inserts a configurable number of wait states.
module tb_fetch_unit;

  logic       clock = 1'b0;
  logic       rst   = 1'b0;
  logic [7:0] pc_addr;
  logic       pc_en, pc_in;
  logic [7:0] pc_data;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       ir_valid;
  logic       ir_ready   = 1'b0;
  logic [7:0] ir_opcode, ir_operand, ir_pc;
  logic       jmp_req    = 1'b0;
  logic [7:0] jmp_target = 8'h00;
  logic       halt       = 1'b0;

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock(clock), .rst(rst), .pc_addr(pc_addr), .pc_en(pc_en), .pc_in(pc_in),
    .pc_data(pc_data), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir_opcode(ir_opcode), .ir_operand(ir_operand), .ir_pc(ir_pc),
    .jmp_req(jmp_req), .jmp_target(jmp_target), .halt(halt)
  );

  // Memory model: ack arrives after 'waits' idle request cycles; stray_ack
  // injects an ack that no request asked for.
  logic [7:0] mem [256];
  int         waits     = 0;
  int         wait_cnt  = 0;
  logic       stray_ack = 1'b0;

  assign mem_ack   = (mem_req && (wait_cnt == waits)) || stray_ack;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clock) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  // Program counter model: increment, or load pc_data when pc_in is set.
  logic [7:0] pc_model;
  always @(posedge clock or negedge rst) begin
    if (!rst)       pc_model <= 8'h00;
    else if (pc_en) pc_model <= pc_in ? pc_data : pc_model + 8'd1;
  end
  assign pc_addr = pc_model;

  typedef struct {
    logic [7:0] opcode;
    logic [7:0] operand;
    logic [7:0] pc;
    int         cycle;
    int         pulses;
  } hs_t;

  hs_t        hs_q[$];
  logic [7:0] ack_addr_q[$];
  int         cycle_cnt = 0;
  int         pulse_cnt = 0;
  int         load_cnt  = 0;
  int         vec_cnt   = 0;
  int         miss_cnt  = 0;
  logic       prev_req  = 1'b0;
  logic       prev_ack  = 1'b0;
  logic [7:0] prev_addr = 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clock) cycle_cnt++;

  // Observe the bus mid-cycle: handshakes, counter pulses, ack addresses and
  // the rule that an unanswered request keeps its address.
  always @(negedge clock) begin
    if (rst) begin
      if (pc_en) pulse_cnt++;
      if (pc_en && pc_in) load_cnt++;
      if (mem_req && mem_ack) ack_addr_q.push_back(mem_addr);
      if (ir_valid && ir_ready)
        hs_q.push_back('{ir_opcode, ir_operand, ir_pc, cycle_cnt, pulse_cnt});
      if (prev_req && !prev_ack && mem_req)
        checkOutput("mem_addr_hold", {24'h0, mem_addr}, {24'h0, prev_addr});
    end
    prev_req  = mem_req && rst;
    prev_ack  = mem_ack;
    prev_addr = mem_addr;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_mem_req"},    {31'h0, mem_req},   32'h0);
    checkOutput({tag, "_mem_addr"},   {24'h0, mem_addr},  32'h0);
    checkOutput({tag, "_pc_en"},      {31'h0, pc_en},     32'h0);
    checkOutput({tag, "_pc_in"},      {31'h0, pc_in},     32'h0);
    checkOutput({tag, "_ir_valid"},   {31'h0, ir_valid},  32'h0);
    checkOutput({tag, "_ir_opcode"},  {24'h0, ir_opcode}, 32'h0);
    checkOutput({tag, "_ir_operand"}, {24'h0, ir_operand},32'h0);
    checkOutput({tag, "_ir_pc"},      {24'h0, ir_pc},     32'h0);
    checkOutput({tag, "_pc_data"},    {24'h0, pc_data},   32'h0);
  endtask

  task automatic doReset(input bit check_idle);
    rst       = 1'b0;
    jmp_req   = 1'b0;
    halt      = 1'b0;
    stray_ack = 1'b0;
    tick();
    if (check_idle) checkIdleOutputs("reset");
    tick();
    hs_q.delete();
    ack_addr_q.delete();
    pulse_cnt = 0;
    load_cnt  = 0;
    rst       = 1'b1;
  endtask

  task automatic clearMem();
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
  endtask

  task automatic waitValid(input string name, input int budget);
    int n;
    n = 0;
    while (!ir_valid && n < budget) begin
      tick();
      n++;
    end
    if (!ir_valid) checkOutput({name, "_valid_timeout"}, 32'h0, 32'h1);
  endtask

  typedef struct {
    int              waits;
    logic [4:0][7:0] img;
  } cfg_t;

  typedef struct {
    int         test_id;
    logic [7:0] opcode;
    logic [7:0] operand;
    logic [7:0] pc;
    int         gap;
    int         pulses;
  } vec_t;

  cfg_t cfgs [3];
  vec_t vecs [9];

  task automatic applyStimulus(input cfg_t c);
    clearMem();
    for (int a = 0; a < 5; a++) mem[a] = c.img[a];
    waits    = c.waits;
    ir_ready = 1'b1;
    doReset(1'b0);
    repeat (40) tick();
  endtask

  initial begin
    // img[i] is the byte at address i
    cfgs[0] = '{0, {8'h00, 8'h00, 8'h00, 8'h02, 8'h01}};
    cfgs[1] = '{0, {8'h55, 8'h81, 8'h07, 8'h3C, 8'h85}};
    cfgs[2] = '{3, {8'h55, 8'h81, 8'h07, 8'h3C, 8'h85}};

    // gap = cycles since previous handshake (-1: not checked), pulses = pc_en count so far
    vecs[0] = '{0, 8'h01, 8'h00, 8'h00, -1, 1};
    vecs[1] = '{0, 8'h02, 8'h00, 8'h01,  2, 2};
    vecs[2] = '{0, 8'h00, 8'h00, 8'h02,  2, 3};
    vecs[3] = '{1, 8'h85, 8'h3C, 8'h00, -1, 2};
    vecs[4] = '{1, 8'h07, 8'h00, 8'h02,  2, 3};
    vecs[5] = '{1, 8'h81, 8'h55, 8'h03,  3, 5};
    vecs[6] = '{2, 8'h85, 8'h3C, 8'h00, -1, 2};
    vecs[7] = '{2, 8'h07, 8'h00, 8'h02,  5, 3};
    vecs[8] = '{2, 8'h81, 8'h55, 8'h03,  9, 5};

    clearMem();
    doReset(1'b1);

    for (int k = 0; k < 3; k++) begin
      int j;
      applyStimulus(cfgs[k]);
      j = 0;
      for (int r = 0; r < 9; r++) begin
        if (vecs[r].test_id == k) begin
          if (j >= hs_q.size()) begin
            checkOutput($sformatf("t%0d_i%0d_missing", k, j), 32'h0, 32'h1);
          end else begin
            checkOutput($sformatf("t%0d_i%0d_opcode", k, j),  {24'h0, hs_q[j].opcode},  {24'h0, vecs[r].opcode});
            checkOutput($sformatf("t%0d_i%0d_operand", k, j), {24'h0, hs_q[j].operand}, {24'h0, vecs[r].operand});
            checkOutput($sformatf("t%0d_i%0d_pc", k, j),      {24'h0, hs_q[j].pc},      {24'h0, vecs[r].pc});
            checkOutput($sformatf("t%0d_i%0d_pulses", k, j),  hs_q[j].pulses,           vecs[r].pulses);
            if (vecs[r].gap >= 0 && j > 0)
              checkOutput($sformatf("t%0d_i%0d_gap", k, j), hs_q[j].cycle - hs_q[j-1].cycle, vecs[r].gap);
          end
          j++;
        end
      end
    end

    // Decoder stall, then a jump taken at the handshake.
    clearMem();
    mem[8'h00] = 8'h01;
    mem[8'h01] = 8'h02;
    mem[8'hF0] = 8'h05;
    waits      = 0;
    ir_ready   = 1'b0;
    doReset(1'b0);
    waitValid("d", 20);
    checkOutput("d_first_opcode", {24'h0, ir_opcode}, 32'h01);
    jmp_req    = 1'b1;
    jmp_target = 8'h40;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("d_stall%0d_valid", i),   {31'h0, ir_valid},  32'h1);
      checkOutput($sformatf("d_stall%0d_opcode", i),  {24'h0, ir_opcode}, 32'h01);
      checkOutput($sformatf("d_stall%0d_operand", i), {24'h0, ir_operand},32'h00);
      checkOutput($sformatf("d_stall%0d_pc", i),      {24'h0, ir_pc},     32'h00);
      checkOutput($sformatf("d_stall%0d_mem_req", i), {31'h0, mem_req},   32'h0);
      checkOutput($sformatf("d_stall%0d_pc_en", i),   {31'h0, pc_en},     32'h0);
    end
    jmp_target = 8'hF0;
    ir_ready   = 1'b1;
    tick();
    ir_ready = 1'b0;
    jmp_req  = 1'b0;
    checkOutput("d_jump_pc_en",   {31'h0, pc_en},   32'h1);
    checkOutput("d_jump_pc_in",   {31'h0, pc_in},   32'h1);
    checkOutput("d_jump_pc_data", {24'h0, pc_data}, 32'hF0);
    checkOutput("d_jump_mem_req", {31'h0, mem_req}, 32'h0);
    tick();
    checkOutput("d_target_mem_req",  {31'h0, mem_req},  32'h1);
    checkOutput("d_target_mem_addr", {24'h0, mem_addr}, 32'hF0);
    checkOutput("d_target_pc_in",    {31'h0, pc_in},    32'h0);
    checkOutput("d_load_pulses",     load_cnt,          32'h1);
    ir_ready = 1'b1;
    repeat (6) tick();
    if (hs_q.size() < 2) begin
      checkOutput("d_after_jump_missing", 32'h0, 32'h1);
    end else begin
      checkOutput("d_after_jump_opcode", {24'h0, hs_q[1].opcode}, 32'h05);
      checkOutput("d_after_jump_pc",     {24'h0, hs_q[1].pc},     32'hF0);
    end

    // Two-byte instruction straddling the address wrap, then halt.
    clearMem();
    mem[8'h00] = 8'h3C;
    mem[8'hFF] = 8'h85;
    waits      = 0;
    ir_ready   = 1'b0;
    doReset(1'b0);
    waitValid("e0", 20);
    checkOutput("e_first_opcode", {24'h0, ir_opcode}, 32'h3C);
    jmp_req    = 1'b1;
    jmp_target = 8'hFF;
    ir_ready   = 1'b1;
    tick();
    jmp_req  = 1'b0;
    ir_ready = 1'b0;
    waitValid("e1", 20);
    checkOutput("e_wrap_opcode",  {24'h0, ir_opcode},  32'h85);
    checkOutput("e_wrap_operand", {24'h0, ir_operand}, 32'h3C);
    checkOutput("e_wrap_pc",      {24'h0, ir_pc},      32'hFF);
    checkOutput("e_ack_count", ack_addr_q.size(), 32'd3);
    if (ack_addr_q.size() >= 3) begin
      checkOutput("e_ack0_addr", {24'h0, ack_addr_q[0]}, 32'h00);
      checkOutput("e_ack1_addr", {24'h0, ack_addr_q[1]}, 32'hFF);
      checkOutput("e_ack2_addr", {24'h0, ack_addr_q[2]}, 32'h00);
    end
    halt       = 1'b1;
    jmp_req    = 1'b1;
    jmp_target = 8'h10;
    ir_ready   = 1'b1;
    tick();
    halt      = 1'b0;
    jmp_req   = 1'b0;
    stray_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("e_halt%0d_mem_req", i), {31'h0, mem_req},   32'h0);
      checkOutput($sformatf("e_halt%0d_valid", i),   {31'h0, ir_valid},  32'h0);
      checkOutput($sformatf("e_halt%0d_pc_en", i),   {31'h0, pc_en},     32'h0);
      checkOutput($sformatf("e_halt%0d_pc_in", i),   {31'h0, pc_in},     32'h0);
      checkOutput($sformatf("e_halt%0d_opcode", i),  {24'h0, ir_opcode}, 32'h85);
      tick();
      stray_ack = 1'b0;
    end

    // Reset in the middle of an operand read with wait states.
    clearMem();
    mem[8'h00] = 8'h85;
    mem[8'h01] = 8'h11;
    waits      = 3;
    ir_ready   = 1'b1;
    doReset(1'b0);
    for (int i = 0; i < 20; i++) begin
      if (ack_addr_q.size() >= 1) break;
      tick();
    end
    checkOutput("e_opcode_ack_seen", {31'h0, ack_addr_q.size() >= 1}, 32'h1);
    tick();
    tick();
    checkOutput("e_arg_mem_req",  {31'h0, mem_req},  32'h1);
    checkOutput("e_arg_mem_addr", {24'h0, mem_addr}, 32'h01);
    rst = 1'b0;
    #1;
    checkIdleOutputs("e_midreset");
    stray_ack = 1'b1;
    tick();
    checkOutput("e_late_ack_mem_req", {31'h0, mem_req}, 32'h0);
    checkOutput("e_late_ack_pc_en",   {31'h0, pc_en},   32'h0);
    tick();
    stray_ack = 1'b0;
    waits     = 0;
    hs_q.delete();
    ack_addr_q.delete();
    rst = 1'b1;
    repeat (8) tick();
    if (hs_q.size() < 1 || ack_addr_q.size() < 1) begin
      checkOutput("e_refetch_missing", 32'h0, 32'h1);
    end else begin
      checkOutput("e_refetch_addr",    {24'h0, ack_addr_q[0]},  32'h00);
      checkOutput("e_refetch_opcode",  {24'h0, hs_q[0].opcode}, 32'h85);
      checkOutput("e_refetch_operand", {24'h0, hs_q[0].operand},32'h11);
      checkOutput("e_refetch_pc",      {24'h0, hs_q[0].pc},     32'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
